e1_bram_ctrl: RTL and testbench
===============================

// Module: e1_bram_ctrl
// PURPOSE
//  Front-end controller for one simple dual-port block RAM (port A write, port B read, 1-cycle read).
//  After reset it clears the whole RAM, then arbitrates between one writer on port A and two
//  round-robin readers on port B, each using a valid/ready handshake.
//  Read data is returned to the requester that issued the read.
//  Sits between the E1 datapath agents and the block RAM instance.
// PARAMETERS
//  DATA_WIDTH  64                   RAM word width
//  DEPTH       64                   RAM words
//  ADDR_WIDTH  $clog2(DEPTH)        address width
//  INIT_VALUE  '0 (DATA_WIDTH bits) word written to every address during the clear sweep
// PORTS
//  clk          in   1           single clock; all logic on posedge
//  rst_n        in   1           reset, asynchronous, active-low
//  init_req     in   1           pulse: request a new clear sweep
//  init_busy    out  1           high while the clear sweep runs
//  wr_valid     in   1           write request
//  wr_ready     out  1           write accepted when wr_valid & wr_ready
//  wr_addr      in   ADDR_WIDTH  write address
//  wr_data      in   DATA_WIDTH  write data
//  rdN_valid    in   1           read request, N = 0,1
//  rdN_ready    out  1           read accepted when rdN_valid & rdN_ready
//  rdN_addr     in   ADDR_WIDTH  read address
//  rdN_rvalid   out  1           rdN_rdata is valid this cycle
//  rdN_rdata    out  DATA_WIDTH  read data returned to requester N
//  bram_en_a    out  1           RAM port A enable
//  bram_we_a    out  1           RAM port A write enable
//  bram_addr_a  out  ADDR_WIDTH  RAM port A address
//  bram_din_a   out  DATA_WIDTH  RAM port A write data
//  bram_en_b    out  1           RAM port B enable
//  bram_addr_b  out  ADDR_WIDTH  RAM port B address
//  bram_dout_b  in   DATA_WIDTH  RAM port B read data, registered inside the RAM
// BEHAVIOUR
//  States: ST_INIT, ST_RUN.
//  - Reset enters ST_INIT with sweep_addr=0.
//  - ST_INIT -> ST_RUN after the cycle that writes address DEPTH-1.
//  - ST_RUN -> ST_INIT on init_req. sweep_addr resets to 0.
//  - init_req during ST_INIT is ignored; the sweep does not restart.
//  Reset values:
//  - init_busy=1; all rdN_rvalid=0; all ready outputs=0.
//  - Round-robin pointer favours rd0.
//  - bram_en_a=1 and bram_we_a=1, because the sweep starts at reset.
//  ST_INIT:
//  - Each cycle writes INIT_VALUE to sweep_addr, then sweep_addr increments.
//  - The sweep takes exactly DEPTH cycles. It stops at DEPTH-1 and never wraps, even for non-power-of-2 DEPTH.
//  - wr_ready=0 and rdN_ready=0 throughout.
//  ST_RUN, write path:
//  - wr_ready=1.
//  - On handshake, bram_en_a, bram_we_a, addr and data are driven combinationally in the same cycle.
//  - bram_en_a=0 when there is no handshake.
//  ST_RUN, read path:
//  - At most one read is granted per cycle. A lone requester always wins.
//  - When both request, the winner is the requester not granted last; the pointer updates only on a contested grant.
//  - rdN_ready is combinational: it equals the grant for N, and is never asserted unless rdN_valid.
//  - bram_en_b=1 only on a grant.
//  Read return:
//  - rdN_rvalid is registered and is 1 exactly one cycle after N's handshake.
//  - rdN_rdata = bram_dout_b when rdN_rvalid=1, else 0.
//  - Back-to-back grants give one result per cycle.
//  Write and read to the same address in the same cycle: the read returns the OLD word (RAM is read-first).
//  init_req while a read is in flight: the in-flight rvalid still fires next cycle; later reads stall until the sweep completes.
//  Reset asserted mid-operation: all state clears asynchronously; pending rvalids are dropped; the sweep restarts from 0.
// STRUCTURE
//  Package e1_bram_pkg:
//  - typedef enum logic {ST_INIT, ST_RUN} e1_bram_state_t
//  - default width constants E1_DATA_W=64 and E1_DEPTH=64
//  Sub-module rr_arb2: 2-way round-robin arbiter with 1-bit pointer.
//  - Inputs: clk, rst_n, req[1:0].
//  - Output: gnt[1:0], one-hot or zero.
//  All other logic lives in this module: FSM, sweep counter, port muxing, return tags.
// TESTING
//  1 Release reset with DEPTH=64 -> init_busy=1 for exactly 64 cycles, 64 writes of INIT_VALUE to addresses 0..63, then wr_ready=1.
//  2 Write 0xA5 to address 5, then rd0 reads address 5 -> rd0_rvalid one cycle after the handshake, rd0_rdata=0xA5, rd1_rvalid stays 0.
//  3 rd0 and rd1 both held valid for 4 cycles -> grants rd0,rd1,rd0,rd1; each rvalid is 1 cycle after its grant.
//  4 Same cycle: write 0x77 to address 9 (old 0x11) and rd1 reads address 9 -> 0x11; repeating the read -> 0x77.
//  5 Pulse init_req while a rd0 read is in flight -> rd0_rvalid still fires; init_busy=1 for 64 cycles; a read afterwards returns INIT_VALUE.
//  6 Assert rst_n=0 mid-sweep at address 30 -> outputs return to reset values immediately; after release the sweep restarts at address 0.

Source files
------------

// File: rtl/e1_bram_ctrl_pkg.sv
// Shared types and default sizes for the E1 block RAM controller.
// Imported by the controller top and its arbiter.
package e1_bram_pkg;

  typedef enum logic {ST_INIT, ST_RUN} e1_bram_state_t;

  localparam int E1_DATA_W = 64;
  localparam int E1_DEPTH  = 64;

endpackage

// File: rtl/e1_bram_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; ptr names the favoured requester.
// A lone requester always wins; ptr moves only on a contested grant.
module rr_arb2
  import e1_bram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (&req) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/e1_bram_ctrl.sv
// Front end for one simple dual-port BRAM: clear sweep after reset,
// one writer on port A, two round-robin readers on port B.
module e1_bram_ctrl
  import e1_bram_pkg::*;
#(
  parameter int DATA_WIDTH = E1_DATA_W,
  parameter int DEPTH      = E1_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_req,
  output logic                  init_busy,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd0_valid,
  output logic                  rd0_ready,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic                  rd0_rvalid,
  output logic [DATA_WIDTH-1:0] rd0_rdata,
  input  logic                  rd1_valid,
  output logic                  rd1_ready,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_rvalid,
  output logic [DATA_WIDTH-1:0] rd1_rdata,
  output logic                  bram_en_a,
  output logic                  bram_we_a,
  output logic [ADDR_WIDTH-1:0] bram_addr_a,
  output logic [DATA_WIDTH-1:0] bram_din_a,
  output logic                  bram_en_b,
  output logic [ADDR_WIDTH-1:0] bram_addr_b,
  input  logic [DATA_WIDTH-1:0] bram_dout_b
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  e1_bram_state_t        state, state_nxt;
  logic [ADDR_WIDTH-1:0] sweep_addr, sweep_nxt;
  logic                  run;
  logic [1:0]            req, gnt;
  logic [1:0]            rvalid_q;

  assign run = (state == ST_RUN);
  assign req = {rd1_valid, rd0_valid} & {2{run}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      sweep_addr <= '0;
      rvalid_q   <= 2'b00;
    end else begin
      state      <= state_nxt;
      sweep_addr <= sweep_nxt;
      rvalid_q   <= gnt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sweep_nxt   = sweep_addr;
    init_busy   = 1'b0;
    wr_ready    = 1'b0;
    bram_en_a   = 1'b0;
    bram_we_a   = 1'b0;
    bram_addr_a = wr_addr;
    bram_din_a  = wr_data;
    unique case (state)
      ST_INIT: begin
        init_busy   = 1'b1;
        bram_en_a   = 1'b1;
        bram_we_a   = 1'b1;
        bram_addr_a = sweep_addr;
        bram_din_a  = INIT_VALUE;
        // Stop on the last word rather than wrapping, so any DEPTH works.
        if (sweep_addr == LAST) begin
          state_nxt = ST_RUN;
        end else begin
          sweep_nxt = sweep_addr + 1'b1;
        end
      end
      ST_RUN: begin
        wr_ready  = 1'b1;
        bram_en_a = wr_valid;
        bram_we_a = wr_valid;
        if (init_req) begin
          state_nxt = ST_INIT;
          sweep_nxt = '0;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign rd0_ready   = gnt[0];
  assign rd1_ready   = gnt[1];
  assign bram_en_b   = |gnt;
  assign bram_addr_b = gnt[1] ? rd1_addr : rd0_addr;

  assign rd0_rvalid = rvalid_q[0];
  assign rd1_rvalid = rvalid_q[1];
  assign rd0_rdata  = rvalid_q[0] ? bram_dout_b : '0;
  assign rd1_rdata  = rvalid_q[1] ? bram_dout_b : '0;

endmodule

// File: tb/tb_e1_bram_ctrl.sv
// Directed and random checks of e1_bram_ctrl against a cycle-level
// reference of sweep, arbitration and read-first memory contents.
module tb_e1_bram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_req = 1'b0;
  logic        init_busy;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        rd0_valid = 1'b0;
  logic        rd0_ready;
  logic [5:0]  rd0_addr = '0;
  logic        rd0_rvalid;
  logic [63:0] rd0_rdata;
  logic        rd1_valid = 1'b0;
  logic        rd1_ready;
  logic [5:0]  rd1_addr = '0;
  logic        rd1_rvalid;
  logic [63:0] rd1_rdata;
  logic        bram_en_a;
  logic        bram_we_a;
  logic [5:0]  bram_addr_a;
  logic [63:0] bram_din_a;
  logic        bram_en_b;
  logic [5:0]  bram_addr_b;
  logic [63:0] bram_dout_b;

  e1_bram_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_req    (init_req),
    .init_busy   (init_busy),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd0_valid   (rd0_valid),
    .rd0_ready   (rd0_ready),
    .rd0_addr    (rd0_addr),
    .rd0_rvalid  (rd0_rvalid),
    .rd0_rdata   (rd0_rdata),
    .rd1_valid   (rd1_valid),
    .rd1_ready   (rd1_ready),
    .rd1_addr    (rd1_addr),
    .rd1_rvalid  (rd1_rvalid),
    .rd1_rdata   (rd1_rdata),
    .bram_en_a   (bram_en_a),
    .bram_we_a   (bram_we_a),
    .bram_addr_a (bram_addr_a),
    .bram_din_a  (bram_din_a),
    .bram_en_b   (bram_en_b),
    .bram_addr_b (bram_addr_b),
    .bram_dout_b (bram_dout_b)
  );

  always #5 clk = ~clk;

  // The block RAM the controller drives: registered, read-first.
  logic [63:0] ram [64];
  always @(posedge clk) begin
    if (bram_en_b) bram_dout_b <= ram[bram_addr_b];
    if (bram_en_a && bram_we_a) ram[bram_addr_a] <= bram_din_a;
  end

  int errors = 0;
  int checks = 0;

  // Reference state
  int          sweep_left;
  bit          fav1;
  logic [63:0] ref_mem [64];
  bit          p0, p1;
  logic [63:0] pv0, pv1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sweep_left = 64;
    fav1 = 1'b0;
    p0 = 1'b0;
    p1 = 1'b0;
  endtask

  task automatic reset_chk();
    @(negedge clk);
    rst_n = 1'b0;
    rd0_valid = 1'b1;
    rd1_valid = 1'b1;
    wr_valid = 1'b1;
    #1;
    chk("rst_busy", init_busy, 1);
    chk("rst_rvalid0", rd0_rvalid, 0);
    chk("rst_rvalid1", rd1_rvalid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd0_ready", rd0_ready, 0);
    chk("rst_rd1_ready", rd1_ready, 0);
    chk("rst_en_a", bram_en_a, 1);
    chk("rst_we_a", bram_we_a, 1);
    chk("rst_addr_a", bram_addr_a, 0);
    model_reset();
  endtask

  task automatic cyc(input bit wv, input logic [5:0] wa,
                     input logic [63:0] wd, input bit r0v,
                     input logic [5:0] r0a, input bit r1v,
                     input logic [5:0] r1a, input bit ini);
    bit running, g0, g1, np0, np1;
    logic [63:0] nv0, nv1;
    int idx;
    @(negedge clk);
    rst_n = 1'b1;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd0_valid = r0v; rd0_addr = r0a;
    rd1_valid = r1v; rd1_addr = r1a;
    init_req = ini;
    #1;
    running = (sweep_left == 0);
    g0 = 1'b0; g1 = 1'b0;
    np0 = 1'b0; np1 = 1'b0;
    nv0 = '0; nv1 = '0;
    if (running) begin
      if (r0v && r1v) begin
        if (fav1) g1 = 1'b1; else g0 = 1'b1;
        fav1 = !fav1;
      end else begin
        g0 = r0v;
        g1 = r1v;
      end
    end
    chk("init_busy", init_busy, !running);
    chk("wr_ready", wr_ready, running);
    chk("rd0_ready", rd0_ready, g0);
    chk("rd1_ready", rd1_ready, g1);
    chk("en_b", bram_en_b, g0 | g1);
    if (g0 | g1) chk("addr_b", bram_addr_b, g0 ? r0a : r1a);
    chk("rd0_rvalid", rd0_rvalid, p0);
    chk("rd0_rdata", rd0_rdata, p0 ? pv0 : 64'd0);
    chk("rd1_rvalid", rd1_rvalid, p1);
    chk("rd1_rdata", rd1_rdata, p1 ? pv1 : 64'd0);
    if (!running) begin
      idx = 64 - sweep_left;
      chk("sweep_en", bram_en_a, 1);
      chk("sweep_we", bram_we_a, 1);
      chk("sweep_addr", bram_addr_a, idx);
      chk("sweep_din", bram_din_a, 0);
      ref_mem[idx] = '0;
      sweep_left--;
    end else begin
      chk("wr_en", bram_en_a, wv);
      if (wv) begin
        chk("wr_we", bram_we_a, 1);
        chk("wr_addr", bram_addr_a, wa);
        chk("wr_din", bram_din_a, wd);
      end
      if (g0) begin np0 = 1'b1; nv0 = ref_mem[r0a]; end
      if (g1) begin np1 = 1'b1; nv1 = ref_mem[r1a]; end
      if (wv) ref_mem[wa] = wd;
      if (ini) sweep_left = 64;
    end
    p0 = np0; pv0 = nv0;
    p1 = np1; pv1 = nv1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cyc($urandom_range(0, 1), 6'($urandom_range(0, 7)), {$urandom, $urandom},
          $urandom_range(0, 1), 6'($urandom_range(0, 7)),
          $urandom_range(0, 1), 6'($urandom_range(0, 7)),
          ($urandom_range(0, 59) == 0));
    end
  endtask

  initial begin
    model_reset();
    reset_chk();
    // Readers held valid through the sweep must not be served.
    repeat (64) cyc(0, 0, 0, 1, 3, 1, 4, 0);
    cyc(1, 5, 64'hA5, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 0, 0, 0);
    idle();
    cyc(1, 9, 64'h11, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 1, 5, 1, 9, 0);
    idle();
    cyc(1, 9, 64'h77, 0, 0, 1, 9, 0);
    cyc(0, 0, 0, 0, 0, 1, 9, 0);
    idle();
    cyc(0, 0, 0, 1, 5, 0, 0, 1);
    repeat (64) cyc(0, 0, 0, 1, 5, 0, 0, 1);
    cyc(0, 0, 0, 1, 5, 0, 0, 0);
    idle();
    rand_cycles(200);
    while (sweep_left != 0) idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (30) idle();
    reset_chk();
    repeat (64) idle();
    rand_cycles(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
